reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath; successor to the single-write, two-read register file.
- Adds a second write port, optional write-to-read bypass, hardwired register 0, asynchronous clear, and a per-register busy scoreboard.
- The busy scoreboard lets the decode stage detect RAW hazards against in-flight writebacks.
- Sits between decode (read and issue) and writeback (two retire lanes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read outputs; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rA  in  ADDR_W  read address, port A.
- rB  in  ADDR_W  read address, port B.
- aData  out  DATA_W  read data, port A.
- bData  out  DATA_W  read data, port B.
- aBusy  out  1  register rA has a pending write.
- bBusy  out  1  register rB has a pending write.
- wEnable0  in  1  write enable, lane 0.
- dR0  in  ADDR_W  write address, lane 0.
- wData0  in  DATA_W  write data, lane 0.
- wEnable1  in  1  write enable, lane 1.
- dR1  in  ADDR_W  write address, lane 1.
- wData1  in  DATA_W  write data, lane 1.
- issueEn  in  1  mark register issueR busy.
- issueR  in  ADDR_W  destination register of the issued instruction.

Behaviour:
- Reset (asynchronous, while rst = 1):
  - All registers are cleared to 0 and all busy bits to 0.
  - aData/bData therefore read 0, and aBusy/bBusy read 0.
  - Writes and issues are ignored while rst is high. A reset asserted mid-operation discards pending busy state immediately, with no clock edge needed.
- Storage: flop array of 2**ADDR_W x DATA_W.
- Writes: committed on the rising clk edge.
  - If both lanes are enabled to the same address, lane 1 wins and lane 0's data is dropped.
  - Writes to address 0 are discarded when ZERO_REG = 1.
- Reads: combinational, zero-cycle latency.
  - BYPASS = 1: if a write lane is enabled to the read address this cycle, the output shows that lane's wData. Lane 1 has priority over lane 0, then the stored value applies.
  - BYPASS = 0: the output shows the stored value; new data is visible the cycle after the edge.
  - ZERO_REG = 1 and address 0: the output is always 0, regardless of bypass.
- Busy scoreboard: one bit per register, updated on the clk edge.
  - Set when issueEn = 1 for issueR.
  - Cleared when any enabled write lane targets that register.
  - If issue and write hit the same register in the same cycle, issue wins and the bit stays/becomes 1 (a new producer is in flight).
  - Issuing to a register that is already busy keeps it busy; there is no count, and the team guarantees at most one outstanding producer per register.
  - ZERO_REG = 1: register 0's busy bit is held at 0.
- Busy reads: aBusy/bBusy are combinational from the stored bits.
  - With BYPASS = 1, a same-cycle write to the read address forces Busy = 0, unless an issue to that same address also occurs this cycle.
- No X propagation: every output is fully defined for all addresses after reset.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W constants;
  - REG_ZERO = 0;
  - the type for the write-lane bundle {en, addr, data}.
- One natural sub-module, reg_file_rd_port: combinational read mux plus bypass and zero logic, instantiated twice (ports A and B).
- Storage and the scoreboard stay in the top level.

Test Plan:
- Reset, then read: assert rst, write 0xFFFFFFFF to r4 while rst is still high. After release, read rA = 4 -> aData = 0, aBusy = 0.
- Basic write and bypass:
  - Write lane 0, dR0 = 4, wData0 = 0xFFFFFFFF, rA = 4 in the same cycle.
  - BYPASS = 1: aData = 0xFFFFFFFF in that cycle.
  - BYPASS = 0: aData = 0 in that cycle and 0xFFFFFFFF on the next.
- Lane conflict: wEnable0 = wEnable1 = 1, dR0 = dR1 = 7, wData0 = 0x11, wData1 = 0x22 -> r7 = 0x22 on the next cycle; the same-cycle bypass also shows 0x22.
- Zero register: write 0xDEADBEEF to r0 and issueR = 0 -> aData = 0 and aBusy = 0 in every following cycle.
- Scoreboard:
  - issueR = 9 -> bBusy = 1 next cycle.
  - Then write lane 1 to r9 with 0x5 -> bBusy = 0 next cycle, bData = 0x5.
  - Issue and write r9 in the same cycle -> bBusy stays 1.
- Reset mid-operation: with r3 busy and holding 0xAB, pulse rst between clock edges -> aBusy = 0 and aData = 0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and write-lane bundle type for the multi-port MIPS register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef struct packed {
    logic                  en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_lane_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: stored-value mux, same-cycle write bypass, zero register
// and busy lookup.
module reg_file_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  parameter type         lane_t   = wr_lane_t,
  localparam int unsigned DEPTH   = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] regs_i [DEPTH],
  input  logic [DEPTH-1:0]  busy_i,
  input  lane_t             lane0_i,
  input  lane_t             lane1_i,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_r_i,
  output logic [DATA_W-1:0] rdata_c,
  output logic              rbusy_c
);

  logic hit0;
  logic hit1;
  logic issue_hit;

  always_comb begin
    hit0      = lane0_i.en && (lane0_i.addr == addr_i);
    hit1      = lane1_i.en && (lane1_i.addr == addr_i);
    issue_hit = issue_en_i && (issue_r_i == addr_i);
    rdata_c   = regs_i[addr_i];
    rbusy_c   = busy_i[addr_i];
    if (BYPASS) begin
      if (hit1) begin
        rdata_c = lane1_i.data;
      end else if (hit0) begin
        rdata_c = lane0_i.data;
      end
      // A retiring write clears the hazard unless a new producer issues in the same cycle.
      if ((hit0 || hit1) && !issue_hit) begin
        rbusy_c = 1'b0;
      end
    end
    if (ZERO_REG && (addr_i == ADDR_W'(REG_ZERO))) begin
      rdata_c = '0;
      rbusy_c = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Two-write, two-read register file with optional bypass, hardwired r0 and a per-register
// busy scoreboard for decode-stage RAW hazard detection.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  output logic [DATA_W-1:0] aData,
  output logic [DATA_W-1:0] bData,
  output logic              aBusy,
  output logic              bBusy,
  input  logic              wEnable0,
  input  logic [ADDR_W-1:0] dR0,
  input  logic [DATA_W-1:0] wData0,
  input  logic              wEnable1,
  input  logic [ADDR_W-1:0] dR1,
  input  logic [DATA_W-1:0] wData1,
  input  logic              issueEn,
  input  logic [ADDR_W-1:0] issueR
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lane_t;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  lane_t             lane0;
  lane_t             lane1;
  logic              issue_en;

  // Lanes and issue are masked during reset so nothing leaks through bypass or the scoreboard.
  always_comb begin
    lane0.en   = wEnable0 && !rst;
    lane0.addr = dR0;
    lane0.data = wData0;
    lane1.en   = wEnable1 && !rst;
    lane1.addr = dR1;
    lane1.data = wData1;
    issue_en   = issueEn && !rst;
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Lane 1 applied last so it wins an address collision.
    if (lane0.en && !(ZERO_REG && (lane0.addr == ADDR_W'(REG_ZERO)))) begin
      regs_d[lane0.addr] = lane0.data;
    end
    if (lane1.en && !(ZERO_REG && (lane1.addr == ADDR_W'(REG_ZERO)))) begin
      regs_d[lane1.addr] = lane1.data;
    end
    if (lane0.en) busy_d[lane0.addr] = 1'b0;
    if (lane1.en) busy_d[lane1.addr] = 1'b0;
    if (issue_en) busy_d[issueR] = 1'b1;
    if (ZERO_REG) busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  reg_file_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG),
    .lane_t  (lane_t)
  ) u_rd_a (
    .addr_i    (rA),
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .lane0_i   (lane0),
    .lane1_i   (lane1),
    .issue_en_i(issue_en),
    .issue_r_i (issueR),
    .rdata_c   (aData),
    .rbusy_c   (aBusy)
  );

  reg_file_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG),
    .lane_t  (lane_t)
  ) u_rd_b (
    .addr_i    (rB),
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .lane0_i   (lane0),
    .lane1_i   (lane1),
    .issue_en_i(issue_en),
    .issue_r_i (issueR),
    .rdata_c   (bData),
    .rbusy_c   (bBusy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed test-plan steps plus random traffic, checked against an
// array-based model of the register file, for both bypass and non-bypass builds.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rA, rB, dR0, dR1, issueR;
  logic [31:0] wData0, wData1;
  logic        wEnable0, wEnable1, issueEn;
  logic [31:0] aData, bData, aData_nb, bData_nb;
  logic        aBusy, bBusy, aBusy_nb, bBusy_nb;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .rA(rA), .rB(rB), .aData(aData), .bData(bData),
    .aBusy(aBusy), .bBusy(bBusy), .wEnable0(wEnable0), .dR0(dR0), .wData0(wData0),
    .wEnable1(wEnable1), .dR1(dR1), .wData1(wData1), .issueEn(issueEn), .issueR(issueR)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .rA(rA), .rB(rB), .aData(aData_nb), .bData(bData_nb),
    .aBusy(aBusy_nb), .bBusy(bBusy_nb), .wEnable0(wEnable0), .dR0(dR0), .wData0(wData0),
    .wEnable1(wEnable1), .dR1(dR1), .wData1(wData1), .issueEn(issueEn), .issueR(issueR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] a);
    if (a == 5'd0 || rst) return '0;
    if (byp && wEnable1 && dR1 == a) return wData1;
    if (byp && wEnable0 && dR0 == a) return wData0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    bit written;
    if (a == 5'd0 || rst) return 1'b0;
    written = (wEnable0 && dR0 == a) || (wEnable1 && dR1 == a);
    if (byp && written && !(issueEn && issueR == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic idle();
    wEnable0 = 0; wEnable1 = 0; issueEn = 0;
    dR0 = 0; dR1 = 0; issueR = 0; wData0 = 0; wData1 = 0;
  endtask

  // Let inputs settle, then compare all eight read outputs with the model.
  task automatic settle();
    #1;
    if (rst) model_clear();
    chk("aData",    aData,                exp_data(1'b1, rA));
    chk("bData",    bData,                exp_data(1'b1, rB));
    chk("aBusy",    32'(aBusy),           32'(exp_busy(1'b1, rA)));
    chk("bBusy",    32'(bBusy),           32'(exp_busy(1'b1, rB)));
    chk("aData_nb", aData_nb,             exp_data(1'b0, rA));
    chk("bData_nb", bData_nb,             exp_data(1'b0, rB));
    chk("aBusy_nb", 32'(aBusy_nb),        32'(exp_busy(1'b0, rA)));
    chk("bBusy_nb", 32'(bBusy_nb),        32'(exp_busy(1'b0, rB)));
  endtask

  // Clock edge: apply writes in lane order, then issue, to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (wEnable0) begin
        if (dR0 != 0) m_mem[dR0] = wData0;
        m_busy[dR0] = 1'b0;
      end
      if (wEnable1) begin
        if (dR1 != 0) m_mem[dR1] = wData1;
        m_busy[dR1] = 1'b0;
      end
      if (issueEn && issueR != 0) m_busy[issueR] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; rA = 0; rB = 0; idle();
    model_clear();
    @(negedge clk);

    // Write during reset is ignored.
    rA = 4; wEnable0 = 1; dR0 = 4; wData0 = 32'hFFFF_FFFF;
    settle(); chk("rst_aData", aData, 32'h0);
    tick();
    rst = 0; idle();
    settle(); chk("post_rst_aData", aData, 32'h0); chk("post_rst_aBusy", 32'(aBusy), 32'h0);
    tick();

    // Basic write with bypass visibility.
    wEnable0 = 1; dR0 = 4; wData0 = 32'hFFFF_FFFF; rA = 4;
    settle(); chk("byp_same", aData, 32'hFFFF_FFFF); chk("nb_same", aData_nb, 32'h0);
    tick(); idle();
    settle(); chk("nb_next", aData_nb, 32'hFFFF_FFFF);
    tick();

    // Lane conflict: lane 1 wins.
    wEnable0 = 1; wEnable1 = 1; dR0 = 7; dR1 = 7; wData0 = 32'h11; wData1 = 32'h22; rA = 7;
    settle(); chk("conflict_byp", aData, 32'h22);
    tick(); idle();
    settle(); chk("conflict_stored", aData_nb, 32'h22);
    tick();

    // Zero register.
    rA = 0; wEnable0 = 1; dR0 = 0; wData0 = 32'hDEAD_BEEF; issueEn = 1; issueR = 0;
    settle(); chk("zero_same", aData, 32'h0); chk("zero_busy_same", 32'(aBusy), 32'h0);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      settle(); chk("zero_after", aData_nb, 32'h0); chk("zero_busy_after", 32'(aBusy_nb), 32'h0);
      tick();
    end

    // Scoreboard set / clear / issue-wins.
    rB = 9; issueEn = 1; issueR = 9;
    settle(); tick(); idle();
    settle(); chk("sb_set", 32'(bBusy), 32'h1);
    wEnable1 = 1; dR1 = 9; wData1 = 32'h5;
    settle(); chk("sb_clr_byp", 32'(bBusy), 32'h0); chk("sb_clr_nb", 32'(bBusy_nb), 32'h1);
    tick(); idle();
    settle(); chk("sb_cleared", 32'(bBusy_nb), 32'h0); chk("sb_data", bData_nb, 32'h5);
    issueEn = 1; issueR = 9; wEnable0 = 1; dR0 = 9; wData0 = 32'h6;
    settle(); tick(); idle();
    settle(); chk("sb_issue_wins", 32'(bBusy), 32'h1); chk("sb_issue_wins_nb", 32'(bBusy_nb), 32'h1);
    tick();

    // Reset pulsed between edges clears state without a clock.
    wEnable0 = 1; dR0 = 3; wData0 = 32'hAB;
    settle(); tick(); idle();
    issueEn = 1; issueR = 3; rA = 3;
    settle(); tick(); idle();
    settle(); chk("pre_rst_busy", 32'(aBusy), 32'h1); chk("pre_rst_data", aData, 32'hAB);
    rst = 1;
    settle(); chk("mid_rst_data", aData, 32'h0); chk("mid_rst_busy", 32'(aBusy), 32'h0);
    rst = 0;
    #1; chk("rel_rst_data", aData_nb, 32'h0); chk("rel_rst_busy", 32'(aBusy_nb), 32'h0);
    tick();

    // Random traffic on a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      rA       = 5'($urandom_range(0, 7));
      rB       = 5'($urandom_range(0, 7));
      wEnable0 = 1'($urandom_range(0, 1));
      wEnable1 = 1'($urandom_range(0, 1));
      dR0      = 5'($urandom_range(0, 7));
      dR1      = 5'($urandom_range(0, 7));
      wData0   = $urandom;
      wData1   = $urandom;
      issueEn  = 1'($urandom_range(0, 1));
      issueR   = 5'($urandom_range(0, 7));
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
